// File: rtl/spatz_vcsr_unit_pkg.sv
// Shared types for the vector CSR unit: request format, vtype layout, CSR addresses
// and the VLMAX helper used when a vsetvl-style configuration commits.
package spatz_vcsr_unit_pkg;

  localparam int unsigned VLEN     = 256;
  localparam int unsigned ELEN     = 32;
  localparam int unsigned VLW      = $clog2(VLEN) + 1;
  localparam int unsigned MAX_VSEW = $clog2(ELEN) - 3;

  typedef logic [VLW-1:0]  vlen_t;
  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic [1:0] {
    CON = 2'd0,
    LSU = 2'd1,
    SLD = 2'd2,
    VFU = 2'd3
  } ex_unit_e;

  typedef enum logic [2:0] {
    VCFG   = 3'd0,
    VCSR   = 3'd1,
    VADD   = 3'd2,
    VLE    = 3'd3,
    VSE    = 3'd4,
    VSLIDE = 3'd5
  } op_e;

  typedef enum logic [11:0] {
    VSTART = 12'h008,
    VL     = 12'hC20,
    VTYPE  = 12'hC21,
    VLENB  = 12'hC22
  } vcsr_addr_e;

  // Bits [7:0] line up with rs2[7:0] of a configuration request.
  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam vtype_t VTYPE_RESET = vtype_t'(9'h100);

  typedef struct packed {
    op_e         op;
    ex_unit_e    ex_unit;
    logic [11:0] csr_addr;
    elen_t       rs1;
    elen_t       rs2;
    logic [4:0]  rd;
    logic        use_rd;
    logic        keep_vl;
    logic        reset_vstart;
    logic        write_vstart;
    logic        set_vstart;
    logic        clear_vstart;
    vtype_t      vtype;
    vlen_t       vl;
    vlen_t       vstart;
  } spatz_req_t;

  // Elements per register group; fractional LMUL codes 5..7 divide instead of multiply.
  function automatic vlen_t vlmax(input vtype_t vt);
    int unsigned v;
    v = VLEN >> (32'd3 + 32'(vt.vsew));
    if (vt.vill) begin
      v = 32'd0;
    end else if (!vt.vlmul[2]) begin
      v = v << vt.vlmul;
    end else begin
      v = v >> (32'd8 - 32'(vt.vlmul));
    end
    return vlen_t'(v);
  endfunction

endpackage

// File: rtl/spatz_vcsr_unit_if.sv
// Handshake bundle between the decoder, the CSR unit, the issue stages and the scalar core.
interface spatz_vcsr_unit_if;
  import spatz_vcsr_unit_pkg::*;

  logic       req_valid_i;
  logic       req_ready_o;
  spatz_req_t req_i;
  logic       issue_valid_o;
  logic       issue_ready_i;
  spatz_req_t issue_req_o;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  elen_t      rsp_data_o;

  modport slave (
    input  req_valid_i, req_i, issue_ready_i, rsp_ready_i,
    output req_ready_o, issue_valid_o, issue_req_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_i, issue_ready_i, rsp_ready_i,
    input  req_ready_o, issue_valid_o, issue_req_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/spatz_out_slot.sv
// One-entry valid/ready output register; it can drain and reload in the same cycle.
module spatz_out_slot #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_load,
  input  T     i_data,
  output logic o_free,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  logic r_valid;
  T     r_data;

  assign o_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load wins over drain so a simultaneous drain+load keeps valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/spatz_vcsr_unit.sv
// Owns vl/vtype/vstart: executes configuration and CSR-access requests, answers rd,
// and stamps the live CSR state onto every other request before issuing it.
module spatz_vcsr_unit
  import spatz_vcsr_unit_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  spatz_vcsr_unit_if.slave        bus,
  output vlen_t                   vl_o,
  output vtype_t                  vtype_o,
  output vlen_t                   vstart_o
);

  vlen_t      r_vl;
  vtype_t     r_vtype;
  vlen_t      r_vstart;

  logic       w_is_con;
  logic       w_issue_free;
  logic       w_rsp_free;
  logic       w_req_ready;
  logic       w_accept;
  vlen_t      w_vl_n;
  vtype_t     w_vtype_n;
  vlen_t      w_vstart_n;
  elen_t      w_rd;
  vtype_t     w_cfg_vt;
  logic       w_cfg_ill;
  vlen_t      w_cfg_max;
  vlen_t      w_wr;
  spatz_req_t w_issue_data;

  // Acceptance: non-CON needs the issue slot, CON needs the rsp slot only when it returns rd.
  always_comb begin
    w_is_con = (bus.req_i.ex_unit == CON);
    if (!w_is_con) begin
      w_req_ready = w_issue_free;
    end else if (bus.req_i.use_rd) begin
      w_req_ready = w_rsp_free;
    end else begin
      w_req_ready = 1'b1;
    end
    w_accept = bus.req_valid_i & w_req_ready;
  end

  // Next CSR state and rd value for the request currently presented.
  always_comb begin
    w_vl_n     = r_vl;
    w_vtype_n  = r_vtype;
    w_vstart_n = r_vstart;
    w_rd       = '0;
    w_cfg_vt   = vtype_t'({1'b0, bus.req_i.rs2[7:0]});
    w_cfg_ill  = (bus.req_i.rs2[ELEN-1:8] != '0) |
                 (w_cfg_vt.vsew > 3'(MAX_VSEW)) |
                 (w_cfg_vt.vlmul == 3'd4);
    w_cfg_max  = vlmax(w_cfg_vt);
    w_wr       = bus.req_i.rs1[VLW-1:0];
    if (!w_is_con) begin
      w_vstart_n = '0;
    end else begin
      case (bus.req_i.op)
        VCFG: begin
          w_vstart_n = '0;
          if (w_cfg_ill) begin
            w_vtype_n = VTYPE_RESET;
            w_vl_n    = '0;
          end else begin
            w_vtype_n = w_cfg_vt;
            if (bus.req_i.keep_vl) begin
              w_vl_n = r_vl;
            end else if (bus.req_i.rs1 > elen_t'(w_cfg_max)) begin
              w_vl_n = w_cfg_max;
            end else begin
              w_vl_n = w_wr;
            end
          end
          w_rd = elen_t'(w_vl_n);
        end
        VCSR: begin
          case (bus.req_i.csr_addr)
            VSTART: begin
              w_rd = elen_t'(r_vstart);
              if (bus.req_i.reset_vstart) begin
                w_vstart_n = '0;
              end else if (bus.req_i.write_vstart) begin
                w_vstart_n = w_wr;
              end else if (bus.req_i.set_vstart) begin
                w_vstart_n = r_vstart | w_wr;
              end else if (bus.req_i.clear_vstart) begin
                w_vstart_n = r_vstart & ~w_wr;
              end else begin
                w_vstart_n = r_vstart;
              end
            end
            VL:      w_rd = elen_t'(r_vl);
            VTYPE: begin
              w_rd[ELEN-1] = r_vtype.vill;
              w_rd[7:0]    = r_vtype[7:0];
            end
            VLENB:   w_rd = elen_t'(VLEN / 32'd8);
            default: w_rd = '0;
          endcase
        end
        default: w_rd = '0;
      endcase
    end
  end

  // Forwarded request carries the CSR state as it stands before this acceptance.
  always_comb begin
    w_issue_data        = bus.req_i;
    w_issue_data.vtype  = r_vtype;
    w_issue_data.vl     = r_vl;
    w_issue_data.vstart = r_vstart;
  end

  // CSR state commits on acceptance so the next request sees it without a gap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vl     <= '0;
      r_vtype  <= VTYPE_RESET;
      r_vstart <= '0;
    end else if (w_accept) begin
      r_vl     <= w_vl_n;
      r_vtype  <= w_vtype_n;
      r_vstart <= w_vstart_n;
    end else begin
      r_vl     <= r_vl;
      r_vtype  <= r_vtype;
      r_vstart <= r_vstart;
    end
  end

  spatz_out_slot #(.T(spatz_req_t)) u_issue_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_accept & ~w_is_con),
    .i_data  (w_issue_data),
    .o_free  (w_issue_free),
    .o_valid (bus.issue_valid_o),
    .i_ready (bus.issue_ready_i),
    .o_data  (bus.issue_req_o)
  );

  spatz_out_slot #(.T(elen_t)) u_rsp_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_accept & w_is_con & bus.req_i.use_rd),
    .i_data  (w_rd),
    .o_free  (w_rsp_free),
    .o_valid (bus.rsp_valid_o),
    .i_ready (bus.rsp_ready_i),
    .o_data  (bus.rsp_data_o)
  );

  assign bus.req_ready_o = w_req_ready;
  assign vl_o            = r_vl;
  assign vtype_o         = r_vtype;
  assign vstart_o        = r_vstart;

endmodule
